// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and byte payload type for the UART transmit path.
package uart_pkg;

  localparam int unsigned CLK_FREQ   = 50_000_000;
  localparam int unsigned BAUD_RATE  = 9600;
  localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD_RATE;

  // Ten bit times (one full frame) at the default clock/baud, rounded down.
  localparam int unsigned ARB_TIMEOUT_DEFAULT = (10 * CLK_FREQ) / BAUD_RATE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    ISSUE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } uart_byte_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: first valid requester at or after rr_ptr.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_valid
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  // Requester index reached by stepping ofs positions past base, wrapping at NUM_REQ.
  function automatic logic [IDW-1:0] rot(input logic [IDW-1:0] base, input int unsigned ofs);
    int unsigned sum;
    sum = (32'(base) + ofs) % NUM_REQ;
    return IDW'(sum);
  endfunction

  logic found;

  // Scan in wrap-around order starting at rr_ptr; the first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[rot(rr_ptr, k)]) begin
        winner = rot(rr_ptr, k);
        found  = 1'b1;
      end
    end
    any_valid = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between NUM_REQ requesters.
// A grant is held until the owner's last byte has been handed to uart_tx.
// Optional: define UART_ARB_TIMEOUT_EN to revoke a grant after TIMEOUT_CYCLES idle LOCK cycles.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 uart_in,
  output logic                       uart_in_valid,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active,
  output logic                       timeout
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] rr_next;
  logic [IDW-1:0] pick_id;
  logic           pick_any;
  uart_byte_t     hold_q, hold_d;
  logic [7:0]     req_byte [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign req_byte[g] = req_data[8*g +: 8];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_q),
    .winner    (pick_id),
    .any_valid (pick_any)
  );

  assign rr_next = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic          to_hit;

  // Idle LOCK cycles so far; the next silent cycle would be the TIMEOUT_CYCLES-th.
  assign to_hit  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign timeout = to_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
`endif

  // State and datapath registers; reset drops any held byte.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // Next-state, handshake and round-robin pointer update.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    req_ready = '0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d     = '0;
    to_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_id;
          state_d = LOCK;
        end
      end
      LOCK: begin
        req_ready[grant_q] = req_valid[grant_q];
        if (req_valid[grant_q]) begin
          hold_d.data = req_byte[grant_q];
          hold_d.last = req_last[grant_q];
          state_d     = ISSUE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (to_hit) begin
          state_d = IDLE;
          rr_d    = rr_next;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ISSUE: begin
        if (tx_ready) begin
          if (hold_q.last) begin
            state_d = IDLE;
            rr_d    = rr_next;
          end else begin
            state_d = LOCK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id      = grant_q;
  assign grant_active  = (state_q != IDLE);
  assign uart_in_valid = (state_q == ISSUE);
  assign uart_in       = hold_q.data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;
`ifdef UART_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           n_rst;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [7:0]     uart_in;
  logic           uart_in_valid, tx_ready;
  logic [1:0]     grant_id;
  logic           grant_active, timeout;
  logic [7:0]     dbyte [N];

  always #5 clk = ~clk;

  assign req_data = {dbyte[3], dbyte[2], dbyte[1], dbyte[0]};

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .uart_in(uart_in),
    .uart_in_valid(uart_in_valid), .tx_ready(tx_ready), .grant_id(grant_id),
    .grant_active(grant_active), .timeout(timeout)
  );

  int total = 0;
  int bad   = 0;

  // Per-requester message sources: {last, byte}
  logic [8:0] src_mem [N][64];
  int         src_rd [N];
  int         src_wr [N];
  logic [N-1:0] en;
  int         gap_pct, txr_pct;

  // Reference model: current owner (-1 = none), byte waiting at uart_tx, rr pointer
  int         m_owner, m_rr, m_wait;
  bit         m_pend, m_last, m_to;
  logic [7:0] m_byte;
  int         cyc;
  logic       prev_ga;
  logic [1:0] prev_gid;

  logic [7:0] tx_byte [$];
  int         tx_id [$];
  int         tx_cyc [$];
  int         gnt_cyc [$];
  int         gnt_id [$];
  int         to_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    src_mem[r][src_wr[r] % 64] = {l, b};
    src_wr[r]++;
  endtask

  function automatic bit all_empty();
    for (int r = 0; r < N; r++) if (src_rd[r] != src_wr[r]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      int idx = (rr + k) % N;
      if (v[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic clear_logs();
    tx_byte.delete(); tx_id.delete(); tx_cyc.delete();
    gnt_cyc.delete(); gnt_id.delete(); to_cyc.delete();
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step();
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    for (int r = 0; r < N; r++) begin
      if (en[2'(r)] && src_rd[r] != src_wr[r] && $urandom_range(99) >= gap_pct) begin
        req_valid[2'(r)] = 1'b1;
        {req_last[2'(r)], dbyte[r]} = src_mem[r][src_rd[r] % 64];
      end else begin
        req_valid[2'(r)] = 1'b0;
        req_last[2'(r)]  = 1'($urandom);
        dbyte[r]         = 8'($urandom);
      end
    end
    tx_ready = ($urandom_range(99) < txr_pct);
    #1;
    exp_rdy = '0;
    if (m_owner >= 0 && !m_pend) exp_rdy[2'(m_owner)] = req_valid[2'(m_owner)];
    chk("grant_active", 32'(grant_active), 32'(m_owner >= 0));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("uart_in_valid", 32'(uart_in_valid), 32'(m_pend));
    chk("timeout", 32'(timeout), 32'(m_to));
    if (m_owner >= 0) chk("grant_id", 32'(grant_id), 32'(m_owner));
    if (m_pend) chk("uart_in", 32'(uart_in), 32'(m_byte));
    if (grant_active && (!prev_ga || grant_id != prev_gid)) begin
      gnt_cyc.push_back(cyc);
      gnt_id.push_back(int'(grant_id));
    end
    if (timeout) to_cyc.push_back(cyc);
    prev_ga  = grant_active;
    prev_gid = grant_id;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (req_valid != '0) begin
        m_owner = pick(req_valid, m_rr);
        m_wait  = 0;
      end
    end else if (!m_pend) begin
      if (req_valid[2'(m_owner)]) begin
        {m_last, m_byte} = src_mem[m_owner][src_rd[m_owner] % 64];
        src_rd[m_owner]++;
        m_pend = 1'b1;
      end else if (TO_EN && m_wait == TO - 1) begin
        m_to    = 1'b1;
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_wait++;
      end
    end else if (tx_ready) begin
      tx_byte.push_back(m_byte);
      tx_id.push_back(m_owner);
      tx_cyc.push_back(cyc);
      m_pend = 1'b0;
      m_wait = 0;
      if (m_last) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    cyc++;
  endtask

  // Run until every queued byte is sent and no grant is held, then one settling cycle.
  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((m_owner >= 0 || !all_empty()) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
    step();
  endtask

  // Assert reset mid-cycle, check outputs clear at once, release on a falling edge.
  task automatic do_reset();
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_grant_active", 32'(grant_active), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_uart_in_valid", 32'(uart_in_valid), 32'd0);
    chk("rst_uart_in", 32'(uart_in), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    for (int r = 0; r < N; r++) src_rd[r] = src_wr[r];
    req_valid = '0;
    en        = '0;
    m_owner = -1; m_pend = 1'b0; m_rr = 0; m_wait = 0; m_to = 1'b0;
    prev_ga = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    int n;
    int pushed;
    n_rst = 1'b1;
    req_valid = '0; req_last = '0; tx_ready = 1'b0;
    for (int r = 0; r < N; r++) begin
      dbyte[r] = 8'h00; src_rd[r] = 0; src_wr[r] = 0;
    end
    en = '0; gap_pct = 0; txr_pct = 100; cyc = 0; prev_gid = 2'd0;
    do_reset();

    // Single requester, three-byte message, tx always ready
    clear_logs();
    push(1, 8'hA5, 1'b0); push(1, 8'h3C, 1'b0); push(1, 8'h7E, 1'b1);
    en = 4'b0010;
    n = cyc;
    drain("t1_drain", 100);
    chk("t1_count", tx_byte.size(), 3);
    chk("t1_b0", 32'(tx_byte[0]), 32'hA5);
    chk("t1_b1", 32'(tx_byte[1]), 32'h3C);
    chk("t1_b2", 32'(tx_byte[2]), 32'h7E);
    chk("t1_first_latency", tx_cyc[0] - n, 2);
    chk("t1_spacing01", tx_cyc[1] - tx_cyc[0], 2);
    chk("t1_spacing12", tx_cyc[2] - tx_cyc[1], 2);
    chk("t1_owner", tx_id[2], 1);
    chk("t1_idle_after", 32'(grant_active), 32'd0);

    // All four requesters, two single-byte messages each, from reset
    do_reset();
    clear_logs();
    for (int r = 0; r < N; r++) begin
      push(r, 8'(16 * r + 1), 1'b1);
      push(r, 8'(16 * r + 2), 1'b1);
    end
    en = 4'b1111;
    drain("t2_drain", 200);
    chk("t2_count", tx_byte.size(), 8);
    for (int k = 0; k < 8; k++) chk("t2_order", tx_id[k], k % N);

    // tx_ready held low for 50 cycles while a byte is presented
    clear_logs();
    push(3, 8'h5A, 1'b1);
    en = 4'b1000;
    txr_pct = 0;
    n = 0;
    while (!m_pend && n < 10) begin step(); n++; end
    chk("t4_reach_issue", 32'(m_pend), 32'd1);
    repeat (50) step();
    chk("t4_no_transfer", tx_byte.size(), 0);
    txr_pct = 100;
    drain("t4_drain", 20);
    chk("t4_one_transfer", tx_byte.size(), 1);
    chk("t4_byte", 32'(tx_byte[0]), 32'h5A);

    // Requester 0 sends two bytes while requester 2 waits
    clear_logs();
    push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1); push(2, 8'h21, 1'b1);
    en = 4'b0101;
    drain("t3_drain", 100);
    chk("t3_count", tx_byte.size(), 3);
    chk("t3_id0", tx_id[0], 0);
    chk("t3_id1", tx_id[1], 0);
    chk("t3_id2", tx_id[2], 2);
    chk("t3_last_grant", gnt_id[gnt_id.size() - 1], 2);
    chk("t3_grant_delay", gnt_cyc[gnt_cyc.size() - 1] - tx_cyc[1], 2);

    // Reset while a byte is being presented; requester 0 must win afterwards
    clear_logs();
    push(2, 8'h66, 1'b0); push(2, 8'h67, 1'b1);
    en = 4'b0100;
    txr_pct = 0;
    n = 0;
    while (!m_pend && n < 10) begin step(); n++; end
    step();
    chk("t6_in_issue", 32'(uart_in_valid), 32'd1);
    do_reset();
    txr_pct = 100;
    clear_logs();
    push(3, 8'h31, 1'b1); push(0, 8'h01, 1'b1);
    en = 4'b1001;
    drain("t6_drain", 100);
    chk("t6_first_grant", gnt_id[0], 0);
    chk("t6_first_byte", 32'(tx_byte[0]), 32'h01);

`ifdef UART_ARB_TIMEOUT_EN
    // Requester 3 stalls inside its message; the grant is revoked
    clear_logs();
    push(3, 8'h55, 1'b0);
    en = 4'b1000;
    drain("t5_drain", 100);
    chk("t5_pulses", to_cyc.size(), 1);
    chk("t5_delay", to_cyc[0] - (tx_cyc[0] + 1), TO);
    clear_logs();
    push(1, 8'h71, 1'b1); push(0, 8'h70, 1'b1);
    en = 4'b0011;
    drain("t5_next_drain", 100);
    chk("t5_next_grant", gnt_id[0], 0);
`endif

    // Randomized traffic with valid gaps and tx back-pressure
    clear_logs();
    pushed = 0;
    for (int r = 0; r < N; r++) begin
      for (int m = 0; m < 3; m++) begin
        int len = int'($urandom_range(4, 1));
        for (int b = 0; b < len; b++) begin
          push(r, 8'($urandom), b == len - 1);
          pushed++;
        end
      end
    end
    en = 4'b1111;
    gap_pct = 25;
    txr_pct = 60;
    drain("rand_drain", 3000);
    chk("rand_count", tx_byte.size(), pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` byte transmitter between `NUM_REQ` requesters. Each requester pushes bytes over a valid/ready handshake and marks the final byte of a message with `req_last`. The grant is held until that last byte has been handed to `uart_tx`, so messages never interleave on the serial line. The block sits between the system-side message sources and the `uart_tx` parallel input.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 52083: idle cycles tolerated inside a locked grant, equal to 10 bit times at 9600 baud on 50 MHz (only used with `UART_ARB_TIMEOUT_EN`).
- `clk` in 1: system clock.
- `n_rst` in 1: asynchronous active-low reset.
- `req_data` in 8*NUM_REQ: byte of requester i in bits [8i+7:8i].
- `req_valid` in NUM_REQ: requester i presents a byte.
- `req_last` in NUM_REQ: presented byte is the last of its message.
- `req_ready` out NUM_REQ: byte of the granted requester taken this cycle.
- `uart_in` out 8: byte to `uart_tx`.
- `uart_in_valid` out 1: `uart_in` valid; held until accepted.
- `tx_ready` in 1: `uart_tx` can accept a byte. Transfer happens on `uart_in_valid && tx_ready`.
- `grant_id` out clog2(NUM_REQ): current owner.
- `grant_active` out 1: a requester holds the grant.
- `timeout` out 1: one-cycle pulse when a grant is revoked.

## Operation
- FSM states:
  - IDLE: no grant.
  - LOCK: granted, waiting for the owner's byte.
  - ISSUE: presenting the byte to `uart_tx`.
- IDLE:
  - If any `req_valid` is high, select the first requester at or after `rr_ptr` in ascending wrap-around order.
  - Register that requester into `grant_id` and go to LOCK.
  - `req_valid` of non-owners is ignored while a grant is held.
- LOCK:
  - `req_ready[grant_id]` = `req_valid[grant_id]` (combinational). All other `req_ready` bits are 0.
  - On a high `req_ready`, capture the byte and its `req_last` into a holding register and go to ISSUE.
- ISSUE:
  - `uart_in_valid`=1 and `uart_in`=holding byte. Both stay stable until `tx_ready` is seen.
  - On transfer with last=0, return to LOCK.
  - On transfer with last=1, go to IDLE and set `rr_ptr` = `grant_id`+1 (mod `NUM_REQ`).
- `grant_active` = (state != IDLE).
- A requester that drops `req_valid` inside its message keeps the grant. It is never preempted except by the timeout feature.
- A requester may deassert `req_valid` without a handshake in any state; nothing is captured in that case.

## Timing
- Reset values:
  - State: IDLE.
  - `rr_ptr`: 0.
  - `grant_id`: 0.
  - `req_ready`, `uart_in_valid`, `grant_active`, `timeout`: 0.
  - `uart_in`: 8'h00.
- Request visible in IDLE at cycle N: grant at N+1, `req_ready` at N+1 (if valid is held), `uart_in_valid` at N+2.
- Within a message, a transfer at cycle M gives `req_ready` for the next byte at M+1 and `uart_in_valid` at M+2. The minimum byte period is therefore 2 cycles plus the `uart_tx` busy time.
- After a last-byte transfer at cycle M, the block is in IDLE at M+1 and the next grant is at M+2.
- `uart_in_valid` never drops before the transfer.
- Reset asserted mid-operation:
  - The block returns to IDLE immediately. The holding byte is discarded.
  - A byte already transferred into `uart_tx` is unaffected.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to LOCK and increments each cycle in LOCK without a handshake.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, `rr_ptr` = `grant_id`+1, and `timeout` pulses for 1 cycle.
  - The counter does not run in ISSUE.
- Undefined:
  - No counter.
  - `timeout` is tied 0.
  - The grant is held until `req_last`.

## Structure
- Shared package `uart_pkg`:
  - FSM state encodings (IDLE=2'd0, LOCK=2'd1, ISSUE=2'd2).
  - Default constants `CLK_FREQ`=50_000_000 and `BAUD_RATE`=9600.
  - A derived `BIT_CYCLES` constant.
- One sub-module, `uart_rr_pick`: a combinational rotating-priority picker. Inputs are `req_valid` and `rr_ptr`; outputs are the winner index and `any_valid`.

## Test plan
- Single requester 1 sends 3 bytes 8'hA5, 8'h3C, 8'h7E (last on 8'h7E), with `tx_ready` held high:
  - `uart_in` sequence is A5, 3C, 7E at 2-cycle spacing.
  - `grant_id`=1 throughout; IDLE after the third byte.
- All 4 requesters valid at once, each with a 1-byte message, starting from reset:
  - Grants go in order 0, 1, 2, 3.
  - A second round then starts at 0.
- Requester 0 sends a 2-byte message while requester 2 is waiting:
  - No byte from requester 2 appears between requester 0's bytes.
  - Requester 2 is granted 2 cycles after requester 0's last transfer.
- `tx_ready` held low for 50 cycles during ISSUE:
  - `uart_in_valid` stays 1 and `uart_in` stays stable.
  - Exactly one transfer occurs when `tx_ready` rises.
- With `UART_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, requester 3 sends 1 non-last byte then drops `req_valid`:
  - `timeout` pulses 16 cycles after LOCK entry.
  - The next grant goes to requester 0.
- `n_rst` asserted while in ISSUE:
  - All outputs are 0 on the same cycle.
  - After release, requester 0 is granted first.
